// File: rtl/color_replace_pkg.sv
// Shared definitions for the colour-replace engine: FSM states, slave register
// map, CTRL bit positions and the pixel-buffer address layout.
package color_replace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_WR,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_P0    = 3'd1;
  localparam logic [2:0] REG_P1    = 3'd2;
  localparam logic [2:0] REG_BASE  = 3'd3;
  localparam logic [2:0] REG_COUNT = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_DONE   = 2;

  localparam int P_Y_LSB = 16;
  localparam int X_SHIFT = 1;
  localparam int Y_SHIFT = 10;

  // Rows are 1 KiB apart, pixels are 2 bytes wide.
  function automatic logic [31:0] pixel_offset(input logic [15:0] x, input logic [15:0] y);
    return (32'(y) << Y_SHIFT) | (32'(x) << X_SHIFT);
  endfunction

endpackage

// File: rtl/color_replace_scan.sv
// Raster x/y walker over the job region; exposes the byte offset of the pixel
// that the next read will target (region origin on load, stepped position otherwise).
module color_replace_scan
  import color_replace_pkg::*;
#(
  parameter int X_BITS = 9,
  parameter int Y_BITS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [X_BITS-1:0] x0,
  input  logic [Y_BITS-1:0] y0,
  input  logic [X_BITS-1:0] x1,
  input  logic [Y_BITS-1:0] y1,
  output logic              last,
  output logic [31:0]       next_offset
);

  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      x_d = x0;
      y_d = y0;
    end else if (x_q == x1) begin
      x_d = x0;
      y_d = y_q + Y_BITS'(1);
    end else begin
      x_d = x_q + X_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (load || step) begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign last        = (x_q == x1) && (y_q == y1);
  assign next_offset = pixel_offset(16'(x_d), 16'(y_d));

endmodule

// File: rtl/nios_system_color_replace.sv
// Colour-replace engine: Avalon-MM slave for job setup/status, FSM that reads each
// pixel of the region and rewrites those equal to the latched match colour.
module nios_system_color_replace
  import color_replace_pkg::*;
#(
  parameter int X_BITS = 9,
  parameter int Y_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic [15:0] color_from,
  input  logic [15:0] color_to,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        m_waitrequest
);

  state_t            state_q, state_d;
  logic [X_BITS-1:0] x0_q, x1_q;
  logic [Y_BITS-1:0] y0_q, y1_q;
  logic [31:0]       base_q;
  logic [15:0]       count_q;
  logic              irq_en_q, done_q;
  logic [15:0]       from_q, to_q, pix_q;
  logic              scan_load, scan_step, scan_last;
  logic [31:0]       scan_offset;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic wr_en, ctrl_wr, idle, start_acc, empty_job;
  assign wr_en     = chipselect && !write_n;
  assign ctrl_wr   = wr_en && (address == REG_CTRL);
  assign idle      = (state_q == ST_IDLE);
  assign start_acc = ctrl_wr && writedata[CTRL_START] && idle;
  assign empty_job = (x1_q < x0_q) || (y1_q < y0_q) || (color_from == color_to);

  color_replace_scan #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) u_scan (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (scan_load),
    .step        (scan_step),
    .x0          (x0_q),
    .y0          (y0_q),
    .x1          (x1_q),
    .y1          (y1_q),
    .last        (scan_last),
    .next_offset (scan_offset)
  );

  always_comb begin
    state_d   = state_q;
    scan_load = 1'b0;
    scan_step = 1'b0;
    case (state_q)
      ST_IDLE: if (start_acc) begin
        scan_load = 1'b1;
        state_d   = empty_job ? ST_DONE : ST_RD;
      end
      ST_RD:   if (!m_waitrequest) state_d = ST_CMP;
      ST_CMP:  state_d = (pix_q == from_q) ? ST_WR : ST_NEXT;
      ST_WR:   if (!m_waitrequest) state_d = ST_NEXT;
      ST_NEXT: if (scan_last) state_d = ST_DONE;
               else begin
                 scan_step = 1'b1;
                 state_d   = ST_RD;
               end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      base_q   <= '0;
      count_q  <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en && idle) begin
        case (address)
          REG_P0:   begin x0_q <= writedata[X_BITS-1:0]; y0_q <= writedata[P_Y_LSB +: Y_BITS]; end
          REG_P1:   begin x1_q <= writedata[X_BITS-1:0]; y1_q <= writedata[P_Y_LSB +: Y_BITS]; end
          REG_BASE: base_q <= writedata;
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
      // Start beats a simultaneous acknowledge; acknowledges during a job are dropped.
      if (start_acc)                                   done_q <= 1'b0;
      else if (state_q == ST_DONE)                     done_q <= 1'b1;
      else if (ctrl_wr && idle && writedata[CTRL_DONE]) done_q <= 1'b0;
      if (start_acc)                                   count_q <= '0;
      else if (state_q == ST_WR && !m_waitrequest)     count_q <= sat_inc16(count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc) begin
      from_q <= color_from;
      to_q   <= color_to;
    end
    if (state_q == ST_RD && !m_waitrequest) pix_q <= m_readdata;
  end

  // Master outputs are only changed on request launch and on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_NEXT: if (state_d == ST_RD) begin
          m_read    <= 1'b1;
          m_address <= base_q + scan_offset;
        end
        ST_RD:  if (!m_waitrequest) m_read <= 1'b0;
        ST_CMP: if (state_d == ST_WR) begin
          m_write     <= 1'b1;
          m_writedata <= to_q;
        end
        ST_WR:  if (!m_waitrequest) m_write <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL: begin
        readdata[CTRL_BUSY]   = !idle;
        readdata[CTRL_IRQ_EN] = irq_en_q;
        readdata[CTRL_DONE]   = done_q;
      end
      REG_P0:    begin readdata[X_BITS-1:0] = x0_q; readdata[P_Y_LSB +: Y_BITS] = y0_q; end
      REG_P1:    begin readdata[X_BITS-1:0] = x1_q; readdata[P_Y_LSB +: Y_BITS] = y1_q; end
      REG_BASE:  readdata = base_q;
      REG_COUNT: readdata[15:0] = count_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = done_q && irq_en_q;

endmodule
